render_controller: RTL and testbench
====================================

// Module: render_controller
// PURPOSE
//  Downstream of the instruction processor: consumes executed instructions (execInst_valid/execInst).
//  On a render instruction it raster-scans the screen and issues one pixel request per pixel to the ray pipeline.
//  It bounds in-flight pixels with a credit counter and drives controller_busy back to the processor until the frame fully drains.
// PARAMETERS
//  H_RES         320  pixels per line
//  V_RES         180  lines per frame
//  MAX_INFLIGHT  16   max pixel requests issued but not yet completed
//  COORD_W       9    width of pixel_x/pixel_y; must hold max(H_RES,V_RES)-1
// PORTS
//  clk_100mhz       in   1            single clock
//  rst              in   1            synchronous, active-high reset
//  inst_valid       in   1            executed instruction valid
//  inst             in   DecodedInst  executed instruction (proctypes)
//  controller_busy  out  1            high while a frame is in progress
//  pix_req_valid    out  1            pixel request valid
//  pix_req_ready    in   1            ray pipeline accepts request
//  pixel_x          out  COORD_W      request column
//  pixel_y          out  COORD_W      request row
//  pix_done         in   1            one-cycle pulse per completed pixel
//  frame_done       out  1            one-cycle pulse when the last pixel completes
//  credit_err       out  1            sticky: pix_done arrived with zero in flight
// BEHAVIOUR
//  Reset values: every output 0; state IDLE; x=y=0; inflight=0.
//  FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
//  - IDLE: inst_valid && inst.iType==opRender -> ISSUE next cycle. Any other iType is ignored.
//  - ISSUE: pix_req_valid=1 when inflight<MAX_INFLIGHT; pixel_x/pixel_y hold the current raster position.
//    - Handshake is valid&&ready; on a handshake, x++; at x==H_RES-1, x wraps to 0 and y++.
//    - Handshake at (H_RES-1,V_RES-1) -> DRAIN.
//  - DRAIN: pix_req_valid=0. When inflight reaches 0 (after any decrement this cycle) -> DONE.
//  - DONE: frame_done=1 for one cycle; x,y cleared -> IDLE.
//  controller_busy = (state!=IDLE). Asserted the cycle after the render instruction is accepted; low in the cycle after DONE.
//  Request rules: pix_req_valid and coordinates stay stable while valid&&!ready; a request is never withdrawn.
//  inflight counter:
//    - handshake alone: +1; pix_done alone: -1; both in the same cycle: unchanged.
//    - Width is clog2(MAX_INFLIGHT+1).
//  pix_done with inflight==0: sets credit_err, counter stays 0. credit_err is cleared only by rst.
//  inst_valid with opRender while busy: ignored, no state change.
//  rst mid-frame: returns to IDLE immediately; outstanding pix_done pulses after reset raise credit_err (bench must avoid).
//  Latency: render inst at cycle N -> first pix_req_valid at N+1.
// CONFIGURATION
//  RENDER_CTRL_PERF_EN defined:
//    - Adds output frame_cycles [31:0].
//    - Counts cycles in ISSUE+DRAIN; value is latched on frame_done and held until the next frame's DONE. Reset value 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  proctypes package: RenderCtrlState enum {RC_IDLE,RC_ISSUE,RC_DRAIN,RC_DONE}, opRender iType value, default H_RES/V_RES constants.
//  Sub-module pixel_scan_counter:
//    - Inputs: advance, clear. Outputs: x, y, last (asserted at (H_RES-1,V_RES-1)).
//    - Wraps x at H_RES-1.
//  Credit counter and FSM stay local to render_controller.
// TESTING
//  1. H_RES=4,V_RES=2, ready=1, pix_done 1 cycle after each req:
//     -> 8 reqs (0,0)..(3,1) in order; frame_done once; busy low afterwards.
//  2. MAX_INFLIGHT=2, pix_done withheld:
//     -> exactly 2 reqs issued, valid drops; one pix_done -> exactly one more req.
//  3. ready low for 5 cycles mid-frame:
//     -> valid held, pixel_x/pixel_y unchanged, no skipped or duplicated coordinate.
//  4. Handshake and pix_done in the same cycle:
//     -> inflight unchanged.
//  5. pix_done in IDLE:
//     -> credit_err=1 and stays 1 through a full frame; cleared by rst.
//  6. rst asserted at pixel (2,1) -> all outputs 0 next cycle; new opRender restarts at (0,0).
//     Second opRender while busy -> no effect.
//     With RENDER_CTRL_PERF_EN, test 1 frame_cycles equals the bench-counted ISSUE+DRAIN cycles.

Source files
------------

// File: rtl/render_controller_pkg.sv
// Shared types for the render controller: instruction encoding, FSM states, default raster geometry.
package render_controller_pkg;

    localparam int unsigned H_RES_DEF        = 320;
    localparam int unsigned V_RES_DEF        = 180;
    localparam int unsigned MAX_INFLIGHT_DEF = 16;
    localparam int unsigned COORD_W_DEF      = 9;
    localparam int unsigned IMM_W            = 32;
    localparam int unsigned REG_W            = 5;

    typedef enum logic [3:0] {
        opNop    = 4'd0,
        opAlu    = 4'd1,
        opLoad   = 4'd2,
        opStore  = 4'd3,
        opBranch = 4'd4,
        opRender = 4'd5
    } InstType;

    typedef struct packed {
        InstType          iType;
        logic [REG_W-1:0] rd;
        logic [IMM_W-1:0] imm;
    } DecodedInst;

    typedef enum logic [1:0] {
        RC_IDLE  = 2'd0,
        RC_ISSUE = 2'd1,
        RC_DRAIN = 2'd2,
        RC_DONE  = 2'd3
    } RenderCtrlState;

    // True when an executed instruction asks for a frame to be rendered.
    function automatic logic is_render(input DecodedInst d);
        return d.iType == opRender;
    endfunction

endpackage

// File: rtl/render_controller_if.sv
// Instruction input and pixel-request bus between processor, render controller and ray pipeline.
interface render_controller_if
    import render_controller_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF
) ();

    logic               inst_valid;
    DecodedInst         inst;
    logic               pix_req_valid;
    logic               pix_req_ready;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               pix_done;

    // Controller side: consumes instructions, issues pixel requests.
    modport master (
        input  inst_valid,
        input  inst,
        input  pix_req_ready,
        input  pix_done,
        output pix_req_valid,
        output pixel_x,
        output pixel_y
    );

    // Environment side: processor plus ray pipeline.
    modport slave (
        output inst_valid,
        output inst,
        output pix_req_ready,
        output pix_done,
        input  pix_req_valid,
        input  pixel_x,
        input  pixel_y
    );

endinterface

// File: rtl/render_controller_scan.sv
// Raster position counter: steps x across a line, then y down the frame.
module pixel_scan_counter #(
    parameter int unsigned H_RES   = 320,
    parameter int unsigned V_RES   = 180,
    parameter int unsigned COORD_W = 9
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               advance_i,
    input  logic               clear_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               last_q, last_d;

    // Next raster position; last is precomputed so it is a flop output.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i) begin
            if (x_q == COORD_W'(H_RES - 1)) begin
                x_d = '0;
                y_d = (y_q == COORD_W'(V_RES - 1)) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
        last_d = (x_d == COORD_W'(H_RES - 1)) && (y_d == COORD_W'(V_RES - 1));
    end

    // Position registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            last_q <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = last_q;

endmodule

// File: rtl/render_controller.sv
// Render controller: raster-scans a frame into credit-limited pixel requests and
// holds controller_busy until every issued pixel has completed.
// Optional feature macro: RENDER_CTRL_PERF_EN adds frame_cycles (ISSUE+DRAIN cycle count).
module render_controller
    import render_controller_pkg::*;
#(
    parameter int unsigned H_RES        = H_RES_DEF,
    parameter int unsigned V_RES        = V_RES_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned COORD_W      = COORD_W_DEF
) (
    input  logic                clk_100mhz,
    input  logic                rst,
    render_controller_if.master bus,
    output logic                controller_busy,
    output logic                frame_done,
    output logic                credit_err
`ifdef RENDER_CTRL_PERF_EN
    ,
    output logic [31:0]         frame_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    RenderCtrlState     state_q, state_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               credit_err_q, credit_err_d;

    logic               hs_c;
    logic               scan_clear_c;
    logic [COORD_W-1:0] scan_x;
    logic [COORD_W-1:0] scan_y;
    logic               scan_last;
    logic               unused_inst_c;

    assign unused_inst_c = ^{bus.inst.rd, bus.inst.imm};

    assign hs_c         = valid_q && bus.pix_req_ready;
    assign scan_clear_c = (state_q == RC_DONE);

    pixel_scan_counter #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .COORD_W (COORD_W)
    ) u_scan (
        .clk_i     (clk_100mhz),
        .rst_i     (rst),
        .advance_i (hs_c),
        .clear_i   (scan_clear_c),
        .x_o       (scan_x),
        .y_o       (scan_y),
        .last_o    (scan_last)
    );

    // Credit accounting, next state and next registered outputs.
    always_comb begin
        inflight_d   = inflight_q;
        credit_err_d = credit_err_q;
        state_d      = state_q;

        if (hs_c && !bus.pix_done) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!hs_c && bus.pix_done && (inflight_q != '0)) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        if (bus.pix_done && (inflight_q == '0)) begin
            credit_err_d = 1'b1;
        end

        case (state_q)
            RC_IDLE: begin
                if (bus.inst_valid && is_render(bus.inst)) begin
                    state_d = RC_ISSUE;
                end
            end
            RC_ISSUE: begin
                if (hs_c && scan_last) begin
                    state_d = RC_DRAIN;
                end
            end
            RC_DRAIN: begin
                if (inflight_d == '0) begin
                    state_d = RC_DONE;
                end
            end
            RC_DONE: begin
                state_d = RC_IDLE;
            end
            default: begin
                state_d = RC_IDLE;
            end
        endcase

        valid_d      = (state_d == RC_ISSUE) && (inflight_d < CNT_W'(MAX_INFLIGHT));
        busy_d       = (state_d != RC_IDLE);
        frame_done_d = (state_d == RC_DONE);
    end

    // State, credit counter and registered outputs.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state_q      <= RC_IDLE;
            inflight_q   <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            credit_err_q <= credit_err_d;
        end
    end

    assign bus.pix_req_valid = valid_q;
    assign bus.pixel_x       = scan_x;
    assign bus.pixel_y       = scan_y;
    assign controller_busy   = busy_q;
    assign frame_done        = frame_done_q;
    assign credit_err        = credit_err_q;

`ifdef RENDER_CTRL_PERF_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;

    // Running ISSUE+DRAIN count; the final DRAIN cycle is folded in as DONE is entered.
    always_comb begin
        cyc_cnt_d      = '0;
        frame_cycles_d = frame_cycles_q;
        if ((state_q == RC_ISSUE) || (state_q == RC_DRAIN)) begin
            cyc_cnt_d = cyc_cnt_q + 32'(1);
        end
        if (state_d == RC_DONE) begin
            frame_cycles_d = cyc_cnt_q + 32'(1);
        end
    end

    // Performance registers.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            cyc_cnt_q      <= '0;
            frame_cycles_q <= '0;
        end else begin
            cyc_cnt_q      <= cyc_cnt_d;
            frame_cycles_q <= frame_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
`endif

endmodule

// File: tb/tb_render_controller.sv
// Scoreboard bench for render_controller on a 4x2 frame with two credits.
module tb_render_controller;
    import render_controller_pkg::*;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 2;
    localparam int unsigned MAXI = 2;
    localparam int unsigned CW   = 9;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } coord_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic frame_done;
    logic credit_err;
`ifdef RENDER_CTRL_PERF_EN
    logic [31:0] frame_cycles;
`endif

    always #5 clk = ~clk;

    render_controller_if #(.COORD_W(CW)) bus ();

    render_controller #(
        .H_RES        (H),
        .V_RES        (V),
        .MAX_INFLIGHT (MAXI),
        .COORD_W      (CW)
    ) dut (
        .clk_100mhz      (clk),
        .rst             (rst),
        .bus             (bus),
        .controller_busy (busy),
        .frame_done      (frame_done),
        .credit_err      (credit_err)
`ifdef RENDER_CTRL_PERF_EN
        ,
        .frame_cycles    (frame_cycles)
`endif
    );

    coord_t exp_q[$];
    int     tests_run      = 0;
    int     tests_failed   = 0;
    int     hs_total       = 0;
    int     model_inflight = 0;
    int     busy_cyc       = 0;
    logic   auto_done      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted request must match the next expected raster coordinate.
    always @(negedge clk) begin
        coord_t e;
        if (!rst && bus.pix_req_valid && bus.pix_req_ready) begin
            hs_total++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("req_x", 64'(bus.pixel_x), 64'(e.x));
                check("req_y", 64'(bus.pixel_y), 64'(e.y));
            end
        end
    end

    task automatic tick();
        logic hs;
        logic dn;
        hs = bus.pix_req_valid && bus.pix_req_ready && !rst;
        dn = bus.pix_done && !rst;
        if (busy && !frame_done) busy_cyc++;
        @(posedge clk);
        #1;
        if (rst) model_inflight = 0;
        else model_inflight = model_inflight + (hs ? 1 : 0) - ((dn && model_inflight > 0) ? 1 : 0);
        bus.pix_done = auto_done && hs;
    endtask

    task automatic push_frame();
        coord_t c;
        for (int y = 0; y < int'(V); y++) begin
            for (int x = 0; x < int'(H); x++) begin
                c.x = CW'(x);
                c.y = CW'(y);
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic send_inst(input InstType op);
        bus.inst_valid = 1'b1;
        bus.inst.iType = op;
        tick();
        bus.inst_valid = 1'b0;
        bus.inst.iType = opNop;
    endtask

    task automatic wait_frame(input string name, input logic manual, output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 100; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (manual) bus.pix_done = (model_inflight > 0);
            tick();
            n++;
        end
        check({name, "_frame_done_seen"}, 64'(seen), 64'd1);
`ifdef RENDER_CTRL_PERF_EN
        check({name, "_frame_cycles"}, 64'(frame_cycles), 64'(busy_cyc));
`endif
        tick();
        check({name, "_busy_after"}, 64'(busy), 64'd0);
        check({name, "_frame_done_pulse"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        int n;
        int hs0;

        rst               = 1'b1;
        bus.inst_valid    = 1'b0;
        bus.inst          = '0;
        bus.inst.iType    = opNop;
        bus.pix_req_ready = 1'b0;
        bus.pix_done      = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(bus.pix_req_valid), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_credit_err", 64'(credit_err), 64'd0);
        check("rst_x", 64'(bus.pixel_x), 64'd0);
        check("rst_y", 64'(bus.pixel_y), 64'd0);
        rst = 1'b0;
        tick();

        // Test 1: free-flowing frame, completion one cycle after each request.
        bus.pix_req_ready = 1'b1;
        auto_done         = 1'b1;
        hs0               = hs_total;
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        check("t1_busy_latency", 64'(busy), 64'd1);
        check("t1_valid_latency", 64'(bus.pix_req_valid), 64'd1);
        wait_frame("t1", 1'b0, n);
        check("t1_cycles", 64'(n), 64'd9);
        check("t1_req_count", 64'(hs_total - hs0), 64'd8);

        // Test 2: completions withheld, credits exhaust at two.
        auto_done = 1'b0;
        hs0       = hs_total;
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        repeat (5) tick();
        check("t2_req_count_stall", 64'(hs_total - hs0), 64'd2);
        check("t2_valid_dropped", 64'(bus.pix_req_valid), 64'd0);
        bus.pix_done = 1'b1;
        tick();
        check("t2_valid_resume", 64'(bus.pix_req_valid), 64'd1);
        check("t2_resume_x", 64'(bus.pixel_x), 64'd2);
        repeat (4) tick();
        check("t2_req_count_one_more", 64'(hs_total - hs0), 64'd3);
        check("t2_valid_dropped_again", 64'(bus.pix_req_valid), 64'd0);

        // Test 4: handshake and completion in the same cycle leave the credit count unchanged.
        bus.pix_done = 1'b1;
        tick();
        check("t4_valid_pre", 64'(bus.pix_req_valid), 64'd1);
        bus.pix_done = 1'b1;
        tick();
        check("t4_valid_same_cycle", 64'(bus.pix_req_valid), 64'd1);
        check("t4_x", 64'(bus.pixel_x), 64'd0);
        check("t4_y", 64'(bus.pixel_y), 64'd1);
        tick();
        check("t4_valid_full", 64'(bus.pix_req_valid), 64'd0);
        wait_frame("t2", 1'b1, n);
        bus.pix_done = 1'b0;
        check("t2_req_count", 64'(hs_total - hs0), 64'd8);
        check("t2_credit_err", 64'(credit_err), 64'd0);

        // Test 3: five-cycle back-pressure mid-frame.
        auto_done = 1'b1;
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        repeat (3) tick();
        check("t3_stall_x", 64'(bus.pixel_x), 64'd3);
        check("t3_stall_y", 64'(bus.pixel_y), 64'd0);
        bus.pix_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_valid", 64'(bus.pix_req_valid), 64'd1);
            check("t3_hold_x", 64'(bus.pixel_x), 64'd3);
            check("t3_hold_y", 64'(bus.pixel_y), 64'd0);
        end
        bus.pix_req_ready = 1'b1;
        wait_frame("t3", 1'b0, n);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // Test 5: completion with nothing in flight is sticky until reset.
        check("t5_err_before", 64'(credit_err), 64'd0);
        bus.pix_done = 1'b1;
        tick();
        check("t5_err_set", 64'(credit_err), 64'd1);
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        wait_frame("t5", 1'b0, n);
        check("t5_err_sticky", 64'(credit_err), 64'd1);
        rst = 1'b1;
        tick();
        check("t5_err_cleared", 64'(credit_err), 64'd0);
        rst = 1'b0;
        tick();

        // Test 6: second render while busy is ignored; reset mid-frame then restart.
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        send_inst(opRender);
        check("t6_ignored_x", 64'(bus.pixel_x), 64'd1);
        check("t6_ignored_busy", 64'(busy), 64'd1);
        repeat (5) tick();
        check("t6_at_x", 64'(bus.pixel_x), 64'd2);
        check("t6_at_y", 64'(bus.pixel_y), 64'd1);
        auto_done         = 1'b0;
        bus.pix_req_ready = 1'b0;
        rst               = 1'b1;
        exp_q.delete();
        tick();
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_valid", 64'(bus.pix_req_valid), 64'd0);
        check("t6_rst_frame_done", 64'(frame_done), 64'd0);
        check("t6_rst_credit_err", 64'(credit_err), 64'd0);
        check("t6_rst_x", 64'(bus.pixel_x), 64'd0);
        check("t6_rst_y", 64'(bus.pixel_y), 64'd0);
        rst = 1'b0;
        tick();
        send_inst(opAlu);
        check("t6_non_render_busy", 64'(busy), 64'd0);
        check("t6_non_render_valid", 64'(bus.pix_req_valid), 64'd0);
        bus.pix_req_ready = 1'b1;
        auto_done         = 1'b1;
        push_frame();
        busy_cyc = 0;
        send_inst(opRender);
        check("t6_restart_valid", 64'(bus.pix_req_valid), 64'd1);
        check("t6_restart_x", 64'(bus.pixel_x), 64'd0);
        check("t6_restart_y", 64'(bus.pixel_y), 64'd0);
        wait_frame("t6", 1'b0, n);
        check("t6_cycles", 64'(n), 64'd9);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t6_credit_err", 64'(credit_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
